// File: rtl/latch_response_checker.sv
// rtl/latch_response_checker.sv - cycle-sampled checker for a level-triggered D latch
// Optional LATCH_CHK_FIRST_ERR_EN: capture the sample index of the first mismatch.
module latch_response_checker #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             lat_en,
    input  logic             lat_d,
    input  logic             lat_q,
    output logic [1:0]       state,
    output logic             exp_q,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        UNINIT      = 2'd0,
        TRANSPARENT = 2'd1,
        HOLD        = 2'd2,
        UNUSED      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             exp_q_q, exp_q_d;
    logic             err_pulse_d, err_flag_q, err_flag_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic             expected_v;
    logic             checked;
    logic             mismatch;

    always_comb begin
        state_d      = state_q;
        exp_q_d      = exp_q_q;
        err_pulse_d  = 1'b0;
        err_flag_d   = err_flag_q;
        err_cnt_d    = err_cnt_q;
        sample_cnt_d = sample_cnt_q;

        unique case (state_q)
            UNINIT:      if (lat_en)  state_d = TRANSPARENT;
            TRANSPARENT: if (!lat_en) state_d = HOLD;
            HOLD:        if (lat_en)  state_d = TRANSPARENT;
            default:     state_d = UNINIT;
        endcase

        expected_v = lat_en ? lat_d : exp_q_q;
        if (lat_en) exp_q_d = lat_d;

        // Until the latch has been opened once there is no defined expectation.
        checked  = lat_en || (state_q != UNINIT);
        // Case equality makes an X/Z on lat_q a mismatch in simulation.
        mismatch = checked && !(lat_q === expected_v);

        if (clr) begin
            err_flag_d   = 1'b0;
            err_cnt_d    = '0;
            sample_cnt_d = '0;
        end else begin
            if (checked && (sample_cnt_q != {CNT_W{1'b1}}))
                sample_cnt_d = sample_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (mismatch) begin
                err_pulse_d = 1'b1;
                err_flag_d  = 1'b1;
                if (err_cnt_q != {ERR_W{1'b1}})
                    err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= UNINIT;
            exp_q_q      <= 1'b0;
            err_pulse    <= 1'b0;
            err_flag_q   <= 1'b0;
            err_cnt_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            exp_q_q      <= exp_q_d;
            err_pulse    <= err_pulse_d;
            err_flag_q   <= err_flag_d;
            err_cnt_q    <= err_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

`ifdef LATCH_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] first_idx_q;

    // err_flag still low means this is the first mismatch since reset/clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            first_idx_q <= '0;
        else if (clr)
            first_idx_q <= '0;
        else if (mismatch && !err_flag_q)
            first_idx_q <= sample_cnt_q;
    end

    assign first_err_idx = first_idx_q;
`else
    assign first_err_idx = '0;
`endif

    assign state      = state_q;
    assign exp_q      = exp_q_q;
    assign err_flag   = err_flag_q;
    assign err_cnt    = err_cnt_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: doc/latch_response_checker.md
LATCH_RESPONSE_CHECKER -- requirements
Module: latch_response_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the sample and first-error index counters.
REQ-002 The block SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single sampling clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of counters and flags.
REQ-006 The block SHALL have port lat_en, input, 1 bit: observed enable of the level-triggered D latch under test.
REQ-007 The block SHALL have port lat_d, input, 1 bit: observed D input of the latch under test.
REQ-008 The block SHALL have port lat_q, input, 1 bit: observed Q output of the latch under test.
REQ-009 The block SHALL have port state, output, 2 bits: checker state.
REQ-010 The block SHALL have port exp_q, output, 1 bit: expected latch value.
REQ-011 The block SHALL have port err_pulse, output, 1 bit: single-cycle mismatch strobe.
REQ-012 The block SHALL have port err_flag, output, 1 bit: sticky mismatch indicator.
REQ-013 The block SHALL have port err_cnt, output, ERR_W bits: saturating mismatch count.
REQ-014 The block SHALL have port sample_cnt, output, CNT_W bits: saturating count of checked samples.
REQ-015 The block SHALL have port first_err_idx, output, CNT_W bits: sample_cnt value at the first mismatch.

Function
REQ-016 The block SHALL sample lat_en, lat_d and lat_q at each rising clk edge; all outputs SHALL be registered and reflect that edge's evaluation.
REQ-017 The state encoding SHALL be UNINIT=0, TRANSPARENT=1, HOLD=2; code 3 is unused and SHALL recover to UNINIT.
REQ-018 State transitions SHALL be: UNINIT -> TRANSPARENT on lat_en=1; TRANSPARENT -> HOLD on lat_en=0; HOLD -> TRANSPARENT on lat_en=1; otherwise hold state.
REQ-019 When lat_en=1, expected value = lat_d at the same edge, and exp_q SHALL load lat_d.
REQ-020 When lat_en=0, expected value = exp_q, and exp_q SHALL hold.
REQ-021 A sample SHALL be checked when lat_en=1, or when lat_en=0 and state is not UNINIT; samples with lat_en=0 in UNINIT SHALL NOT be checked or counted.
REQ-022 A mismatch SHALL be declared when lat_q differs from the expected value; lat_q of X/Z SHALL count as a mismatch.
REQ-023 On a mismatch: err_pulse=1 for exactly one cycle, err_flag set sticky, err_cnt incremented, saturating at all-ones.
REQ-024 sample_cnt SHALL increment on every checked sample, saturating at all-ones; the mismatch index is the pre-increment value.
REQ-025 clr=1 SHALL zero err_cnt, sample_cnt, first_err_idx, err_flag and err_pulse, and SHALL leave state and exp_q unchanged.
REQ-026 clr SHALL take priority over a simultaneous mismatch: no pulse, no flag, and the count stays at 0.
REQ-027 Checking SHALL latency-free resume on the edge after clr deasserts.

Reset
REQ-028 rst_n=0 SHALL immediately force state=UNINIT, exp_q=0, err_pulse=0, err_flag=0, err_cnt=0, sample_cnt=0 and first_err_idx=0, regardless of clk.
REQ-029 Reset asserted mid-run SHALL discard the held expectation; after release, hold-phase samples SHALL be ignored until lat_en=1 is seen.
REQ-030 Reset release SHALL take effect at the first rising clk edge with rst_n=1.

Configuration
REQ-031 With LATCH_CHK_FIRST_ERR_EN defined, first_err_idx SHALL capture the sample index of the first mismatch since reset/clr, and SHALL hold it until the next reset/clr.
REQ-032 With LATCH_CHK_FIRST_ERR_EN undefined, first_err_idx SHALL be constant 0 and no capture register SHALL be inferred.

Verification
REQ-033 Reset, then lat_en=0, lat_d=1, lat_q=0 for 3 cycles -> state=0, sample_cnt=0, err_flag=0.
REQ-034 lat_en=1, lat_d=0, lat_q=0, then lat_en=0, lat_d toggling 1/0/1, lat_q=0 for 3 cycles -> state goes 1 then 2, exp_q=0, sample_cnt=4, err_cnt=0.
REQ-035 In HOLD with exp_q=0, faulty lat_q follows lat_d=1 -> err_pulse for one cycle, err_flag=1, err_cnt=1, first_err_idx equal to the pre-increment sample_cnt (macro defined) or 0 (macro undefined).
REQ-036 300 consecutive mismatches with ERR_W=8 -> err_cnt=255 and held; clr for one cycle during a mismatch -> all counters 0 and err_flag=0.
REQ-037 rst_n=0 pulsed mid-HOLD, then lat_en=0 with lat_q=1 -> no error; lat_en=1, lat_d=1, lat_q=1 -> state=1, exp_q=1, no error.
